sim_fetch_ctrl: RTL and testbench
=================================

Name: sim_fetch_ctrl

Overview:
- Initiator side of the simulator lookup interface (pc_try / pc_factual / inst / miss).
- Owns the fetch PC and presents one pc_try per cycle to the simulator interface, which answers combinationally in the same cycle.
- On a hit, buffers {pc, inst} into a small FIFO for the downstream core model.
- On a miss, redirects the PC to pc_factual.
- Detects runaway redirect loops and protocol violations.

Parameters:
XLEN, 64, width of PCs
ILEN, 32, instruction width
RESET_PC, 64'h0000000000001000, fetch PC after reset
FIFO_DEPTH, 4, output buffer entries (power of 2, >=2)
MAX_MISS, 8, consecutive misses before error

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  fetch enable; 0 holds PC and issues no samples
pc_try  out  XLEN  PC presented to simulator interface
pc_factual  in  XLEN  simulator's actual PC, valid when miss=1
inst  in  ILEN  instruction at pc_try, valid when miss=0
miss  in  1  1 = pc_try differs from simulator's PC
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head
out_pc  out  XLEN  PC of head entry
out_inst  out  ILEN  instruction of head entry
redirect_cnt  out  32  total misses taken, saturating
err  out  1  sticky error flag
err_code  out  2  0 none, 1 miss loop, 2 misaligned pc_factual, 3 self-redirect

Behaviour:
- Reset (async assert, sync deassert use): pc_try=RESET_PC, FIFO empty, out_valid=0, out_pc/out_inst=0, redirect_cnt=0, miss streak=0, err=0, err_code=0, state=IDLE.
- States:
  - IDLE: entered on reset or en=0. pc_try held, no sampling. Moves to FETCH when en=1.
  - FETCH: sample taken at a posedge when en=1 and the FIFO is not full. In FETCH, en=0 returns to IDLE.
  - ERROR: absorbing, left only by rst.
- Hit (miss=0): push {pc_try, inst}; pc_try <= pc_try+4 (mod 2^XLEN, wraps 0xFFFF_FFFF_FFFF_FFFC -> 0); miss streak <= 0.
- Miss (miss=1): no push; redirect_cnt++ (saturating at 2^32-1); miss streak++.
  - pc_factual[1:0]!=0 -> ERROR, code 2, pc_try unchanged.
  - pc_factual==pc_try -> ERROR, code 3.
  - Otherwise pc_try <= pc_factual.
- Miss streak reaching MAX_MISS -> ERROR, code 1; pc_try keeps the last redirect target.
- Error precedence in a single cycle: 2 > 3 > 1.
- FIFO full: no sample; pc_try held. If out_ready pops the head in the same cycle, the sample is still blocked (no bypass; decision is based on registered full).
- Empty FIFO: out_valid=0; the head fields keep their last values.
- Pop occurs when out_valid && out_ready.
- Simultaneous push and pop: both happen; occupancy is unchanged.
- Hit-to-output latency: 1 cycle (out_valid rises the cycle after the sampling edge).
- ERROR state:
  - No further samples.
  - FIFO continues to drain normally.
  - err/err_code stay stable until rst.
- Reset mid-operation: FIFO contents discarded; all outputs return to reset values immediately.

Decomposition:
- Package sim_intf_pkg:
  - XLEN_DEF, ILEN_DEF.
  - fetch_entry_t struct {pc, inst}.
  - fetch_state_e {IDLE, FETCH, ERROR}.
  - err_code_e {ERR_NONE, ERR_LOOP, ERR_MISALIGN, ERR_SELF}.
- Sub-module sim_fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with full/empty and registered outputs. The top level holds the FSM, PC register, and counters.

Test Plan:
- Reset then en=1; simulator hits at 0x1000, 0x1004 with inst 0x00000013, 0x00100093 -> out_pc/out_inst stream (0x1000,0x13),(0x1004,0x100093); pc_try=0x1008.
- pc_try 0x1008 missed with pc_factual=0xAAAA1008, then hit -> redirect_cnt=1, next out_pc=0xAAAA1008, pc_try=0xAAAA100C.
- out_ready=0 with 4 hits -> out_valid=1, pc_try frozen at 4th+1 PC. Then out_ready=1 for 1 cycle -> exactly one pop, sampling resumes the following cycle.
- 8 consecutive misses cycling 0xBBBB1008/0xCCCC1010 -> err=1, err_code=1 at the 8th edge, no further pc_try changes.
- Miss with pc_factual=0x1012 -> err_code=2. Separate run: miss with pc_factual==pc_try=0x100C -> err_code=3.
- rst asserted mid-stream with 3 FIFO entries -> out_valid=0 and pc_try=0x1000 without waiting for a clk edge.

Source files
------------

// File: rtl/sim_intf_pkg.sv
// Shared types for the simulator lookup interface fetch path.
// Holds default widths, the buffered fetch entry, FSM states and error codes.
package sim_intf_pkg;

    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ERROR = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_LOOP     = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_SELF     = 2'd3
    } err_code_e;

endpackage

// File: rtl/sim_fetch_fifo.sv
// Synchronous FIFO of fetch entries with a registered head.
// Ports: clk, rst, push/din (write), pop (read), dout/valid (head), full.
module sim_fetch_fifo
    import sim_intf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output fetch_entry_t dout,
    output logic         valid,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_nxt;
    logic [AW:0]    count;
    fetch_entry_t   head_q;
    logic           do_push;
    logic           do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign rd_nxt  = rd_ptr + 1'b1;
    assign dout    = head_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_nxt;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            // Head register keeps its last value once the FIFO empties.
            if (do_pop) begin
                if (count > (AW+1)'(1)) begin
                    head_q <= mem[rd_nxt];
                end else if (do_push) begin
                    head_q <= din;
                end
            end else if (!valid && do_push) begin
                head_q <= din;
            end
        end
    end

endmodule

// File: rtl/sim_fetch_ctrl.sv
// Fetch controller driving the simulator lookup interface.
// Ports: en, pc_try/pc_factual/inst/miss, out_* stream, redirect_cnt, err/err_code.
module sim_fetch_ctrl
    import sim_intf_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter int              ILEN       = ILEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0000000000001000,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_MISS   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [XLEN-1:0] pc_try,
    input  logic [XLEN-1:0] pc_factual,
    input  logic [ILEN-1:0] inst,
    input  logic            miss,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    output logic [31:0]     redirect_cnt,
    output logic            err,
    output logic [1:0]      err_code
);

    localparam int SW = $clog2(MAX_MISS + 1);

    fetch_state_e    state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [SW-1:0]   streak_q, streak_n;
    logic [31:0]     cnt_q, cnt_n;
    logic            err_q, err_n;
    err_code_e       code_q, code_n;
    logic            push;
    logic            full;
    fetch_entry_t    din;
    fetch_entry_t    head;

    assign din.pc   = pc_q;
    assign din.inst = inst;

    sim_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (out_ready),
        .dout  (head),
        .valid (out_valid),
        .full  (full)
    );

    assign pc_try       = pc_q;
    assign out_pc       = head.pc;
    assign out_inst     = head.inst;
    assign redirect_cnt = cnt_q;
    assign err          = err_q;
    assign err_code     = code_q;

    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        streak_n = streak_q;
        cnt_n    = cnt_q;
        err_n    = err_q;
        code_n   = code_q;
        push     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (!full) begin
                    if (!miss) begin
                        push     = 1'b1;
                        pc_n     = pc_q + XLEN'(4);
                        streak_n = '0;
                    end else begin
                        if (cnt_q != '1) begin
                            cnt_n = cnt_q + 32'd1;
                        end
                        streak_n = streak_q + 1'b1;
                        // Misaligned target is not followed; others are.
                        if (pc_factual[1:0] != 2'b00) begin
                            state_n = ERROR;
                            err_n   = 1'b1;
                            code_n  = ERR_MISALIGN;
                        end else begin
                            pc_n = pc_factual;
                            if (pc_factual == pc_q) begin
                                state_n = ERROR;
                                err_n   = 1'b1;
                                code_n  = ERR_SELF;
                            end else if (streak_n == SW'(MAX_MISS)) begin
                                state_n = ERROR;
                                err_n   = 1'b1;
                                code_n  = ERR_LOOP;
                            end
                        end
                    end
                end
            end
            ERROR: begin
                state_n = ERROR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            streak_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_n;
            pc_q     <= pc_n;
            streak_q <= streak_n;
            cnt_q    <= cnt_n;
            err_q    <= err_n;
            code_q   <= code_n;
        end
    end

endmodule

// File: tb/tb_sim_fetch_ctrl.sv
// Directed bench for sim_fetch_ctrl with a scoreboard on the output stream.
// Drives the simulator side of the lookup interface and checks outputs.
module tb_sim_fetch_ctrl;
    import sim_intf_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic [63:0] pc_try;
    logic [63:0] pc_factual;
    logic [31:0] inst;
    logic        miss;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] redirect_cnt;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    fetch_entry_t exp_q[$];

    sim_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .pc_try       (pc_try),
        .pc_factual   (pc_factual),
        .inst         (inst),
        .miss         (miss),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .redirect_cnt (redirect_cnt),
        .err          (err),
        .err_code     (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [31:0] i, input bit expect_push);
        miss = 1'b0;
        inst = i;
        if (expect_push) begin
            exp_q.push_back('{pc: pc_try, inst: i});
        end
    endtask

    task automatic redir(input logic [63:0] target);
        miss       = 1'b1;
        pc_factual = target;
    endtask

    // Scoreboard: a pop happens at the next edge when valid && ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                chk("out_pc", out_pc, exp_q[0].pc);
                chk("out_inst", 64'(out_inst), 64'(exp_q[0].inst));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        miss       = 1'b0;
        inst       = '0;
        pc_factual = '0;
        out_ready  = 1'b1;
        #12;
        chk("rst_pc", pc_try, 64'h1000);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_cnt", 64'(redirect_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_code", 64'(err_code), 64'd0);
        step();
        rst = 1'b0;
        en  = 1'b1;
        step();
        chk("fetch_start_pc", pc_try, 64'h1000);

        // Two hits in sequence.
        hit(32'h0000_0013, 1);
        step();
        hit(32'h0010_0093, 1);
        step();
        chk("pc_after_hits", pc_try, 64'h1008);

        // Redirect then hit at the new target.
        redir(64'hAAAA_1008);
        step();
        chk("redir_cnt", 64'(redirect_cnt), 64'd1);
        chk("redir_pc", pc_try, 64'hAAAA_1008);
        hit(32'h0000_0513, 1);
        step();
        chk("pc_after_redir_hit", pc_try, 64'hAAAA_100C);

        // Fill the FIFO with the consumer stalled.
        en = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        en        = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            hit(32'h100 + 32'(k), 1);
            step();
        end
        chk("full_valid", 64'(out_valid), 64'd1);
        chk("full_pc", pc_try, 64'hAAAA_101C);
        hit(32'h200, 0);
        step();
        step();
        chk("full_pc_held", pc_try, 64'hAAAA_101C);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_no_bypass_pc", pc_try, 64'hAAAA_101C);
        hit(32'h201, 1);
        step();
        chk("resume_pc", pc_try, 64'hAAAA_1020);
        out_ready = 1'b1;
        en        = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
        end
        chk("drain_sb", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_head_kept", out_pc, 64'hAAAA_101C);

        // Redirect loop.
        en = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            redir((k % 2 == 0) ? 64'hBBBB_1008 : 64'hCCCC_1010);
            if (k == 7) begin
                chk("loop_err_before", 64'(err), 64'd0);
            end
            step();
        end
        chk("loop_err", 64'(err), 64'd1);
        chk("loop_code", 64'(err_code), 64'd1);
        chk("loop_pc", pc_try, 64'hCCCC_1010);
        chk("loop_cnt", 64'(redirect_cnt), 64'd9);
        redir(64'hBBBB_1008);
        step();
        step();
        chk("loop_pc_frozen", pc_try, 64'hCCCC_1010);
        chk("loop_cnt_frozen", 64'(redirect_cnt), 64'd9);
        chk("loop_code_stable", 64'(err_code), 64'd1);

        // Wrap, then a misaligned redirect.
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        redir(64'hFFFF_FFFF_FFFF_FFFC);
        step();
        hit(32'hDEAD_BEEF, 1);
        step();
        chk("wrap_pc", pc_try, 64'd0);
        redir(64'h1012);
        step();
        chk("misalign_err", 64'(err), 64'd1);
        chk("misalign_code", 64'(err_code), 64'd2);
        chk("misalign_pc", pc_try, 64'd0);
        chk("misalign_cnt", 64'(redirect_cnt), 64'd2);
        chk("misalign_sb", 64'(exp_q.size()), 64'd0);

        // Self-redirect with three entries held, then async reset.
        rst = 1'b1;
        exp_q.delete();
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            hit(32'h300 + 32'(k), 0);
            step();
        end
        chk("self_pre_pc", pc_try, 64'h100C);
        redir(64'h100C);
        step();
        chk("self_err", 64'(err), 64'd1);
        chk("self_code", 64'(err_code), 64'd3);
        chk("self_valid", 64'(out_valid), 64'd1);
        chk("self_head_pc", out_pc, 64'h1000);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_pc", pc_try, 64'h1000);
        chk("async_err", 64'(err), 64'd0);
        chk("async_out_pc", out_pc, 64'd0);
        step();
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
